// File: rtl/conv_result_streamer_pkg.sv
// Shared convolution package: frame geometry defaults, index width and
// the result streamer state encoding.
package conv_result_streamer_pkg;

  localparam int ROWS_DEF = 6;
  localparam int COLS_DEF = 6;
  localparam int DW_DEF   = 16;
  localparam int IDX_W    = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } conv_state_e;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] row,
                                       input logic [IDX_W-1:0] col,
                                       input logic [IDX_W-1:0] last_row,
                                       input logic [IDX_W-1:0] last_col);
    return (row == last_row) && (col == last_col);
  endfunction

endpackage

// File: rtl/conv_result_streamer_result_frame_buffer.sv
// Frame buffer: parallel capture of a whole result frame and an
// asynchronous indexed read of one word.
module result_frame_buffer
  import conv_result_streamer_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] wr_data [0:ROWS-1][0:COLS-1],
  input  logic [IDX_W-1:0]     rd_row,
  input  logic [IDX_W-1:0]     rd_col,
  output logic signed [DW-1:0] rd_data
);

  logic signed [DW-1:0] mem_r [0:ROWS-1][0:COLS-1];

  // Whole-frame capture; contents survive reset by design
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r <= wr_data;
    end
  end

  // Indexed read of the requested word
  always_comb begin
    rd_data = mem_r[rd_row][rd_col];
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Converts a parallel convolution result frame into a row-major
// valid/ready word stream with back-to-back frame support.
module conv_result_streamer
  import conv_result_streamer_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 out_st,
  input  logic signed [DW-1:0] dout [0:ROWS-1][0:COLS-1],
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic [IDX_W-1:0]     m_row,
  output logic [IDX_W-1:0]     m_col,
  output logic                 m_last,
  output logic                 busy,
  output logic                 overflow
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

  conv_state_e          state_r, state_nxt_s;
  logic [IDX_W-1:0]     row_r, col_r, row_nxt_s, col_nxt_s;
  logic signed [DW-1:0] data_r, data_nxt_s, rd_data_s;
  logic                 last_r, last_nxt_s;
  logic                 overflow_r, overflow_nxt_s;
  logic                 xfer_s, last_xfer_s, capture_s;

  result_frame_buffer #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (capture_s),
    .wr_data (dout),
    .rd_row  (row_nxt_s),
    .rd_col  (col_nxt_s),
    .rd_data (rd_data_s)
  );

  // Next state, counters and the word presented after the next edge
  always_comb begin
    state_nxt_s    = state_r;
    row_nxt_s      = row_r;
    col_nxt_s      = col_r;
    data_nxt_s     = {DW{1'b0}};
    last_nxt_s     = 1'b0;
    xfer_s         = (state_r == ST_STREAM) && m_ready;
    last_xfer_s    = xfer_s && last_r;
    capture_s      = out_st && ((state_r == ST_IDLE) || last_xfer_s);
    overflow_nxt_s = out_st && (state_r == ST_STREAM) && !last_xfer_s;

    if (capture_s) begin
      state_nxt_s = ST_STREAM;
      row_nxt_s   = {IDX_W{1'b0}};
      col_nxt_s   = {IDX_W{1'b0}};
    end else if (last_xfer_s) begin
      state_nxt_s = ST_IDLE;
      row_nxt_s   = {IDX_W{1'b0}};
      col_nxt_s   = {IDX_W{1'b0}};
    end else if (xfer_s) begin
      if (col_r == LAST_COL) begin
        col_nxt_s = {IDX_W{1'b0}};
        row_nxt_s = row_r + 3'd1;
      end else begin
        col_nxt_s = col_r + 3'd1;
        row_nxt_s = row_r;
      end
    end else begin
      state_nxt_s = state_r;
    end

    // Buffer is written on the capture edge, so the first word comes from dout
    if (state_nxt_s == ST_STREAM) begin
      data_nxt_s = capture_s ? dout[0][0] : rd_data_s;
      last_nxt_s = is_last_idx(row_nxt_s, col_nxt_s, LAST_ROW, LAST_COL);
    end else begin
      data_nxt_s = {DW{1'b0}};
      last_nxt_s = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      row_r      <= {IDX_W{1'b0}};
      col_r      <= {IDX_W{1'b0}};
      data_r     <= {DW{1'b0}};
      last_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      row_r      <= row_nxt_s;
      col_r      <= col_nxt_s;
      data_r     <= data_nxt_s;
      last_r     <= last_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  assign m_valid  = (state_r == ST_STREAM);
  assign busy     = (state_r == ST_STREAM);
  assign m_data   = data_r;
  assign m_row    = m_valid ? row_r : {IDX_W{1'b0}};
  assign m_col    = m_valid ? col_r : {IDX_W{1'b0}};
  assign m_last   = last_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed self-checking bench for conv_result_streamer.
module tb_conv_result_streamer;

  localparam int ROWS = 6;
  localparam int COLS = 6;
  localparam int DW   = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 out_st = 1'b0;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] dout [0:ROWS-1][0:COLS-1];
  logic                 m_valid;
  logic signed [DW-1:0] m_data;
  logic [2:0]           m_row;
  logic [2:0]           m_col;
  logic                 m_last;
  logic                 busy;
  logic                 overflow;

  int tests  = 0;
  int failed = 0;

  conv_result_streamer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .out_st   (out_st),
    .dout     (dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: r*10+c, 1: -(r*6+c)-1, 2: 32767, 3: -32768, 4: 999
  task automatic fill(input int mode);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        case (mode)
          0: dout[r][c] = 16'(r * 10 + c);
          1: dout[r][c] = 16'(-(r * 6 + c) - 1);
          2: dout[r][c] = 16'sh7FFF;
          3: dout[r][c] = 16'sh8000;
          default: dout[r][c] = 16'(999);
        endcase
      end
    end
  endtask

  task automatic chk_word(input string tag, input int k, input int exp_data);
    chk($sformatf("%s[%0d].valid", tag, k), int'(m_valid), 1);
    chk($sformatf("%s[%0d].data", tag, k), int'(m_data), exp_data);
    chk($sformatf("%s[%0d].row", tag, k), int'(m_row), k / COLS);
    chk($sformatf("%s[%0d].col", tag, k), int'(m_col), k % COLS);
    chk($sformatf("%s[%0d].last", tag, k), int'(m_last), (k == ROWS * COLS - 1) ? 1 : 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, int'(m_valid), 0);
    chk({tag, ".data"}, int'(m_data), 0);
    chk({tag, ".row"}, int'(m_row), 0);
    chk({tag, ".col"}, int'(m_col), 0);
    chk({tag, ".last"}, int'(m_last), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".ovf"}, int'(overflow), 0);
  endtask

  initial begin
    fill(0);
    #1 reset = 1'b1;
    #1 chk_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_idle("idle_after_reset");

    // Frame r*10+c with m_ready held high
    m_ready = 1'b1;
    out_st = 1'b1;
    step();
    out_st = 1'b0;
    chk("f1.busy", int'(busy), 1);
    for (int k = 0; k < 36; k++) begin
      chk_word("f1", k, (k / 6) * 10 + (k % 6));
      step();
    end
    chk_idle("f1_end");

    // Negative frame with m_ready toggling
    fill(1);
    out_st = 1'b1;
    step();
    out_st = 1'b0;
    for (int i = 0; i < 72; i++) begin
      m_ready = (i % 2 == 1);
      chk_word("f2", i / 2, -(i / 2) - 1);
      step();
    end
    chk_idle("f2_end");

    // Back-to-back frame captured on the last transfer
    fill(0);
    m_ready = 1'b1;
    out_st = 1'b1;
    step();
    out_st = 1'b0;
    for (int k = 0; k < 36; k++) begin
      chk_word("b2b_a", k, (k / 6) * 10 + (k % 6));
      chk($sformatf("b2b_a[%0d].ovf", k), int'(overflow), 0);
      if (k == 35) begin
        fill(2);
        out_st = 1'b1;
      end
      step();
      out_st = 1'b0;
    end
    for (int k = 0; k < 36; k++) begin
      chk_word("b2b_b", k, 32767);
      chk($sformatf("b2b_b[%0d].ovf", k), int'(overflow), 0);
      step();
    end
    chk_idle("b2b_end");

    // Dropped out_st mid-frame
    fill(0);
    out_st = 1'b1;
    step();
    out_st = 1'b0;
    for (int k = 0; k < 36; k++) begin
      chk_word("ovf", k, (k / 6) * 10 + (k % 6));
      chk($sformatf("ovf[%0d].ovf", k), int'(overflow), (k == 11) ? 1 : 0);
      if (k == 10) begin
        fill(4);
        out_st = 1'b1;
      end
      step();
      out_st = 1'b0;
    end
    chk_idle("ovf_end");

    // Asynchronous reset mid-frame, then restart
    fill(0);
    out_st = 1'b1;
    step();
    out_st = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
    end
    chk_word("pre_rst", 20, 32);
    #2 reset = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge clk);
    reset = 1'b0;
    fill(1);
    out_st = 1'b1;
    step();
    out_st = 1'b0;
    for (int k = 0; k < 36; k++) begin
      chk_word("restart", k, -k - 1);
      step();
    end
    chk_idle("restart_end");

    // Long stall on the most negative value
    fill(3);
    m_ready = 1'b0;
    out_st = 1'b1;
    step();
    out_st = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk_word("stall", 0, -32768);
      step();
    end
    m_ready = 1'b1;
    for (int k = 0; k < 36; k++) begin
      chk_word("drain", k, -32768);
      step();
    end
    chk_idle("drain_end");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/conv_result_streamer.md
CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

Interface
REQ-001 Parameter ROWS, default 6, number of result rows per frame.
REQ-002 Parameter COLS, default 6, number of result columns per frame.
REQ-003 Parameter DW, default 16, signed result word width.
REQ-004 Port clk  input  1  single clock; all logic rising-edge triggered.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port out_st  input  1  frame-ready strobe from the convolution core; one-cycle pulse.
REQ-007 Port dout  input  signed DW x [0:ROWS-1][0:COLS-1]  parallel convolution result; valid only in the out_st cycle.
REQ-008 Port m_valid  output  1  stream word valid.
REQ-009 Port m_ready  input  1  downstream accepts word.
REQ-010 Port m_data  output  signed DW  current result word.
REQ-011 Port m_row  output  3  row index of m_data.
REQ-012 Port m_col  output  3  column index of m_data.
REQ-013 Port m_last  output  1  high with the final word of a frame.
REQ-014 Port busy  output  1  high while a captured frame is not fully transferred.
REQ-015 Port overflow  output  1  one-cycle pulse when an out_st is dropped.

Function
REQ-016 The block SHALL implement two states: IDLE and STREAM.
REQ-017 In IDLE, out_st high SHALL capture all ROWS*COLS words of dout into an internal frame buffer, zero row/col counters, and enter STREAM on the next edge.
REQ-018 m_valid SHALL rise the cycle after the capturing out_st (latency 1) and stay high throughout STREAM.
REQ-019 A transfer SHALL occur exactly in a cycle with m_valid and m_ready both high.
REQ-020 While m_valid is high and m_ready low, m_data, m_row, m_col, m_last SHALL remain unchanged.
REQ-021 Words SHALL be emitted in row-major order: (0,0),(0,1)..(0,COLS-1),(1,0)..(ROWS-1,COLS-1).
REQ-022 m_data SHALL equal the buffered word at [m_row][m_col]; sign preserved, no truncation.
REQ-023 m_last SHALL be high only when m_row=ROWS-1 and m_col=COLS-1.
REQ-024 On the transfer of the m_last word with no out_st in that cycle, the block SHALL return to IDLE and drop m_valid next cycle.
REQ-025 out_st in the same cycle as the m_last transfer SHALL be accepted: new frame captured, counters zeroed, state stays STREAM, m_valid stays high (back-to-back, no bubble).
REQ-026 out_st during STREAM other than per REQ-025 SHALL be ignored, buffer untouched, and overflow pulsed high for one cycle, the cycle after that out_st.
REQ-027 busy SHALL equal (state == STREAM).
REQ-028 m_data, m_row, m_col, m_last SHALL be zero whenever m_valid is low.

Reset
REQ-029 Asserting reset SHALL immediately force state IDLE, counters 0, m_valid 0, m_data 0, m_row 0, m_col 0, m_last 0, busy 0, overflow 0, regardless of clk.
REQ-030 Reset mid-frame SHALL abandon the frame; the buffer contents need not be cleared.
REQ-031 The first out_st after reset deasserts SHALL be handled as in REQ-017.

Structure
REQ-032 ROWS, COLS, DW defaults and the state enumeration SHALL live in the shared convolution package also used by the convolution core.
REQ-033 One sub-module, result_frame_buffer (ROWS*COLS x DW register array, parallel write, indexed read), SHALL hold the frame; control FSM and counters stay in the top.

Verification
REQ-034 dout[r][c]=r*10+c, out_st pulse, m_ready=1 -> 36 words 0,1..5,10..55 on consecutive cycles, m_last on word 55 only, busy low after.
REQ-035 dout[r][c]=-(r*6+c)-1, m_ready toggling 1/0 each cycle -> values -1..-36 in order, each stable while m_ready=0, 72 cycles total.
REQ-036 out_st at the m_last transfer cycle with second frame all 16'sh7FFF -> m_valid continuous, next 36 words 32767, overflow never asserted.
REQ-037 out_st at word index 10 of a frame -> overflow high one cycle, stream continues with original values, no extra words.
REQ-038 reset asserted asynchronously at word index 20 -> all outputs 0 without a clock edge; next out_st restarts at (0,0).
REQ-039 dout all 16'sh8000, m_ready=0 for 50 cycles then 1 -> m_data holds -32768 at (0,0) for 50 cycles, then 36 transfers.
